// File: rtl/toggle_event_decoder_pkg.sv
// toggle_event_decoder_pkg: shared state encoding and default parameters
//   state_t          - burst FSM encoding (IDLE, ACTIVE)
//   DEF_CNT_W        - default burst counter / snapshot width
//   DEF_SYNC_STAGES  - default synchroniser depth
//   DEF_TIMEOUT      - default idle cycles that end a burst
package toggle_event_decoder_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 16;

endpackage

// File: rtl/toggle_sync_edge.sv
// toggle_sync_edge: synchronises a toggle line and flags each level change
//   clk    in  rising-edge clock
//   rstn   in  synchronous active-low reset
//   tog_in in  asynchronous toggle line
//   pulse  out high in the cycle the synchronised line differs from the
//              reference bit (driven from flops only, no input path)
module toggle_sync_edge
    import toggle_event_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rstn,
    input  logic tog_in,
    output logic pulse
);

    localparam int PW = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ref_q, ref_d;
    logic [PW-1:0]          prime_q, prime_d;
    logic                   primed;

    // The reference bit always follows the synchroniser; priming only masks
    // the comparison so a line held high across reset is absorbed silently.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], tog_in};
        ref_d   = sync_q[SYNC_STAGES-1];
        primed  = (prime_q == PW'(SYNC_STAGES + 1));
        prime_d = primed ? prime_q : prime_q + 1'b1;
        pulse   = primed && (sync_q[SYNC_STAGES-1] != ref_q);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q  <= '0;
            ref_q   <= 1'b0;
            prime_q <= '0;
        end else begin
            sync_q  <= sync_d;
            ref_q   <= ref_d;
            prime_q <= prime_d;
        end
    end

endmodule

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: decodes a toggle-encoded event line into pulses,
// counts events per burst and publishes burst length on a snapshot port
//   clk        in  rising-edge clock
//   rstn       in  synchronous active-low reset
//   tog_in     in  asynchronous toggle line, one event per level change
//   clr        in  clears count and sticky flags
//   pulse_out  out one-cycle pulse per decoded event
//   count      out events in current/last burst (saturating)
//   active     out burst in progress
//   snap_valid out snapshot available
//   snap_ready in  consumer accepts snapshot
//   snap_data  out burst length captured at burst end
//   overflow   out sticky: burst exceeded counter range
//   snap_lost  out sticky: burst ended while a snapshot was pending
module toggle_event_decoder
    import toggle_event_decoder_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tog_in,
    input  logic             clr,
    output logic             pulse_out,
    output logic [CNT_W-1:0] count,
    output logic             active,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [CNT_W-1:0] snap_data,
    output logic             overflow,
    output logic             snap_lost
);

    localparam int               TW      = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             pulse;
    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pulse_q;
    logic             snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0] snap_data_q, snap_data_d;
    logic             overflow_q, overflow_d;
    logic             snap_lost_q, snap_lost_d;
    logic             capture, take, ovf_inc;

    toggle_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rstn   (rstn),
        .tog_in (tog_in),
        .pulse  (pulse)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = clr ? '0 : count_q;
        ovf_inc = 1'b0;
        capture = 1'b0;
        if (pulse) begin
            state_d = ACTIVE;
            timer_d = '0;
            // A cleared or fresh burst keeps the coincident event as the first one.
            if (state_q == IDLE || clr)
                count_d = CNT_W'(1);
            else if (count_q == CNT_MAX)
                ovf_inc = 1'b1;
            else
                count_d = count_q + 1'b1;
        end else if (state_q == ACTIVE) begin
            if (timer_q == TW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                timer_d = '0;
                capture = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
        // A capture may load when the slot is free or being drained this edge.
        take         = capture && (!snap_valid_q || snap_ready);
        snap_valid_d = take || (snap_valid_q && !snap_ready);
        snap_data_d  = take ? count_q : snap_data_q;
        overflow_d   = ovf_inc || (overflow_q && !clr);
        snap_lost_d  = (capture && !take) || (snap_lost_q && !clr);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            count_q      <= '0;
            pulse_q      <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_data_q  <= '0;
            overflow_q   <= 1'b0;
            snap_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            pulse_q      <= pulse;
            snap_valid_q <= snap_valid_d;
            snap_data_q  <= snap_data_d;
            overflow_q   <= overflow_d;
            snap_lost_q  <= snap_lost_d;
        end
    end

    assign pulse_out  = pulse_q;
    assign count      = count_q;
    assign active     = (state_q == ACTIVE);
    assign snap_valid = snap_valid_q;
    assign snap_data  = snap_data_q;
    assign overflow   = overflow_q;
    assign snap_lost  = snap_lost_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// tb_toggle_event_decoder: directed bench for toggle_event_decoder with a
// snapshot scoreboard; a second instance with a 3-bit counter covers saturation
module tb_toggle_event_decoder;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic tog = 1'b1;
    logic clr = 1'b0;
    logic rdy = 1'b0;

    logic       m_pulse, m_active, m_snap_valid, m_overflow, m_snap_lost;
    logic [7:0] m_count, m_snap_data;
    logic       s_pulse, s_active, s_snap_valid, s_overflow, s_snap_lost;
    logic [2:0] s_count, s_snap_data;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    toggle_event_decoder dut (
        .clk        (clk),
        .rstn       (rstn),
        .tog_in     (tog),
        .clr        (clr),
        .pulse_out  (m_pulse),
        .count      (m_count),
        .active     (m_active),
        .snap_valid (m_snap_valid),
        .snap_ready (rdy),
        .snap_data  (m_snap_data),
        .overflow   (m_overflow),
        .snap_lost  (m_snap_lost)
    );

    toggle_event_decoder #(.CNT_W(3)) dut_s (
        .clk        (clk),
        .rstn       (rstn),
        .tog_in     (tog),
        .clr        (clr),
        .pulse_out  (s_pulse),
        .count      (s_count),
        .active     (s_active),
        .snap_valid (s_snap_valid),
        .snap_ready (rdy),
        .snap_data  (s_snap_data),
        .overflow   (s_overflow),
        .snap_lost  (s_snap_lost)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count decoded pulses and retire scoreboard entries on each transfer.
    always @(negedge clk) begin
        if (m_pulse) pulse_cnt++;
        if (rstn && m_snap_valid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_transfer", 32'(m_snap_data), 32'hFFFF_FFFF);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("xfer_data", 32'(m_snap_data), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // n toggles spaced 4 cycles; returns just after the capture edge.
    task automatic burst(input int n, input bit late_rdy);
        int base;
        base = pulse_cnt;
        tog = ~tog;
        tick(2);
        chk("pre_pulse", 32'(m_pulse), 0);
        tick(1);
        chk("first_pulse", 32'(m_pulse), 1);
        chk("first_count", 32'(m_count), 1);
        chk("first_active", 32'(m_active), 1);
        tick(1);
        for (int i = 1; i < n; i++) begin
            tog = ~tog;
            tick(4);
            chk("burst_active", 32'(m_active), 1);
        end
        tick(14);
        chk("pre_timeout_active", 32'(m_active), 1);
        if (late_rdy) rdy = 1'b1;
        tick(1);
        chk("timeout_idle", 32'(m_active), 0);
        chk("snap_valid_up", 32'(m_snap_valid), 1);
        chk("pulse_total", 32'(pulse_cnt - base), 32'(n));
    endtask

    initial begin
        tick(3);
        chk("rst_pulse", 32'(m_pulse), 0);
        chk("rst_count", 32'(m_count), 0);
        chk("rst_active", 32'(m_active), 0);
        chk("rst_valid", 32'(m_snap_valid), 0);
        chk("rst_data", 32'(m_snap_data), 0);
        chk("rst_ovf", 32'(m_overflow), 0);
        chk("rst_lost", 32'(m_snap_lost), 0);
        rstn = 1'b1;
        tick(40);
        chk("prime_pulses", 32'(pulse_cnt), 0);
        chk("prime_active", 32'(m_active), 0);
        chk("prime_count", 32'(m_count), 0);

        rdy = 1'b1;
        exp_q.push_back(5);
        burst(5, 1'b0);
        chk("b5_data", 32'(m_snap_data), 5);
        chk("b5_count", 32'(m_count), 5);
        tick(1);
        chk("b5_accepted", 32'(m_snap_valid), 0);

        exp_q.push_back(9);
        burst(9, 1'b0);
        chk("sat_count", 32'(s_count), 7);
        chk("sat_ovf", 32'(s_overflow), 1);
        chk("sat_data", 32'(s_snap_data), 7);
        chk("wide_data", 32'(m_snap_data), 9);
        chk("wide_ovf", 32'(m_overflow), 0);
        tick(1);
        chk("sat_accepted", 32'(s_snap_valid), 0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_ovf", 32'(s_overflow), 0);
        chk("clr_count_s", 32'(s_count), 0);
        chk("clr_count_m", 32'(m_count), 0);

        rdy = 1'b0;
        exp_q.push_back(3);
        burst(3, 1'b0);
        chk("hold_data3", 32'(m_snap_data), 3);
        burst(4, 1'b0);
        chk("lost_data_kept", 32'(m_snap_data), 3);
        chk("lost_flag", 32'(m_snap_lost), 1);
        chk("lost_count", 32'(m_count), 4);
        rdy = 1'b1;
        tick(1);
        chk("lost_drained", 32'(m_snap_valid), 0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_lost", 32'(m_snap_lost), 0);

        rdy = 1'b0;
        exp_q.push_back(2);
        burst(2, 1'b0);
        chk("pend_data2", 32'(m_snap_data), 2);
        exp_q.push_back(3);
        burst(3, 1'b1);
        chk("swap_data", 32'(m_snap_data), 3);
        chk("swap_no_lost", 32'(m_snap_lost), 0);
        tick(1);
        chk("swap_drained", 32'(m_snap_valid), 0);

        for (int i = 0; i < 6; i++) begin
            tog = ~tog;
            tick(4);
        end
        chk("mid_count", 32'(m_count), 6);
        chk("mid_active", 32'(m_active), 1);
        tog = 1'b1;
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        chk("mrst_pulse", 32'(m_pulse), 0);
        chk("mrst_count", 32'(m_count), 0);
        chk("mrst_active", 32'(m_active), 0);
        chk("mrst_valid", 32'(m_snap_valid), 0);
        chk("mrst_data", 32'(m_snap_data), 0);
        chk("mrst_ovf", 32'(m_overflow), 0);
        chk("mrst_lost", 32'(m_snap_lost), 0);
        begin
            int base;
            base = pulse_cnt;
            for (int i = 0; i < 3; i++) begin
                tick(1);
                chk("reprime_pulse", 32'(m_pulse), 0);
            end
            tick(10);
            chk("reprime_total", 32'(pulse_cnt - base), 0);
            chk("reprime_active", 32'(m_active), 0);
        end
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
